// File: rtl/tank_shell_if.sv
// tank_shell_if: bundles the tank-shell block's data signals.
//   keycode     - current keyboard keycode (to shell)
//   TankX/TankY - tank position (to shell)
//   hit         - collision logic reports the live shell hit something (to shell)
//   ShellX/ShellY, ShellActive, Fired - registered shell state (from shell)
// Modports: master = the environment around the shell (keyboard, tank, collision),
//           slave  = the tank_shell block itself.
interface tank_shell_if;
  logic [7:0] keycode;
  logic [9:0] TankX;
  logic [9:0] TankY;
  logic       hit;
  logic [9:0] ShellX;
  logic [9:0] ShellY;
  logic       ShellActive;
  logic       Fired;

  modport master (
    output keycode, TankX, TankY, hit,
    input  ShellX, ShellY, ShellActive, Fired
  );

  modport slave (
    input  keycode, TankX, TankY, hit,
    output ShellX, ShellY, ShellActive, Fired
  );
endinterface

// File: rtl/tank_shell.sv
// tank_shell: launches a single shell from just above the tank on a fire-key
// press, moves it up Shell_Step pixels per frame until it leaves the top of the
// playfield or is hit, then holds off further shots for Cooldown_Frames frames.
// Ports:
//   frame_clk - frame-rate clock, all updates on its rising edge
//   Reset_n   - synchronous active-low reset
//   bus       - tank_shell_if.slave (keycode, TankX, TankY, hit in;
//               ShellX, ShellY, ShellActive, Fired out, all registered)
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | no shell live, waiting for a fire-key press edge
// ST_FLYING   | shell live, rising one step per frame
// ST_COOLDOWN | reload: down-counter runs to 1, presses are discarded
module tank_shell #(
  parameter logic [7:0] Fire_Key        = 8'h2C,
  parameter logic [9:0] Shell_Step      = 10'd4,
  parameter logic [9:0] Spawn_Offset    = 10'd8,
  parameter logic [9:0] Shell_Y_Min     = 10'd0,
  parameter logic [7:0] Cooldown_Frames = 8'd15
) (
  input  logic      frame_clk,
  input  logic      Reset_n,
  tank_shell_if.slave bus
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_FLYING   = 2'd1;
  localparam logic [1:0] ST_COOLDOWN = 2'd2;

  // Exit threshold widened by one bit so Shell_Y_Min + Shell_Step cannot wrap.
  localparam logic [10:0] TopLimit = {1'b0, Shell_Y_Min} + {1'b0, Shell_Step};

  logic [1:0] state_q, state_d;
  logic [9:0] shell_x_q, shell_x_d;
  logic [9:0] shell_y_q, shell_y_d;
  logic       active_q, active_d;
  logic       fired_q, fired_d;
  logic [7:0] cnt_q, cnt_d;
  logic       key_prev_q, key_prev_d;

  logic fire_key_now;
  logic fire_req;
  logic at_top;

  assign fire_key_now = (bus.keycode == Fire_Key);
  assign fire_req     = fire_key_now && !key_prev_q;
  assign at_top       = ({1'b0, shell_y_q} < TopLimit);

  always_comb begin
    state_d    = state_q;
    shell_x_d  = shell_x_q;
    shell_y_d  = shell_y_q;
    active_d   = active_q;
    cnt_d      = cnt_q;
    fired_d    = 1'b0;
    key_prev_d = fire_key_now;

    case (state_q)
      ST_IDLE: begin
        // A press while the tank is too close to the top is dropped rather
        // than spawning a shell at a wrapped Y.
        if (fire_req && (bus.TankY >= Spawn_Offset)) begin
          shell_x_d = bus.TankX;
          shell_y_d = bus.TankY - Spawn_Offset;
          active_d  = 1'b1;
          fired_d   = 1'b1;
          state_d   = ST_FLYING;
        end
      end

      ST_FLYING: begin
        if (bus.hit || at_top) begin
          // Position is frozen at the point of exit for the mapper.
          active_d = 1'b0;
          cnt_d    = Cooldown_Frames;
          state_d  = (Cooldown_Frames == 8'd0) ? ST_IDLE : ST_COOLDOWN;
        end else begin
          shell_y_d = shell_y_q - Shell_Step;
        end
      end

      ST_COOLDOWN: begin
        // <= 1 also recovers cleanly should the counter ever read 0 here.
        if (cnt_q <= 8'd1) begin
          cnt_d   = 8'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        active_d = 1'b0;
        cnt_d    = 8'd0;
      end
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      shell_x_q  <= 10'd0;
      shell_y_q  <= 10'd0;
      active_q   <= 1'b0;
      fired_q    <= 1'b0;
      cnt_q      <= 8'd0;
      key_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shell_x_q  <= shell_x_d;
      shell_y_q  <= shell_y_d;
      active_q   <= active_d;
      fired_q    <= fired_d;
      cnt_q      <= cnt_d;
      key_prev_q <= key_prev_d;
    end
  end

  assign bus.ShellX      = shell_x_q;
  assign bus.ShellY      = shell_y_q;
  assign bus.ShellActive = active_q;
  assign bus.Fired       = fired_q;

endmodule

// File: tb/tb_tank_shell.sv
// tb_tank_shell: drives tank_shell with directed scenarios and random frames.
// Every driven frame pushes the reference model's expected outputs into a
// queue; a monitor pops one entry per rising edge and compares.
module tb_tank_shell;

  localparam int KEY_FIRE = 8'h2C;
  localparam int STEP     = 4;
  localparam int OFFSET   = 8;
  localparam int Y_MIN    = 0;
  localparam int COOL     = 15;

  logic frame_clk = 1'b1;
  logic Reset_n   = 1'b0;

  tank_shell_if bus();

  tank_shell dut (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .bus       (bus)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       act;
    logic       fired;
  } exp_t;

  exp_t sb_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int dut_fired_cnt = 0;

  // Reference model: shell is either live, reloading (frames left), or ready.
  int m_x = 0, m_y = 0, m_cd = 0;
  bit m_active = 0, m_prev = 0, m_fired = 0;

  // Monitor: one expected entry per rising edge, compared just after it.
  always @(posedge frame_clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_tests++;
      if (bus.ShellX !== e.x || bus.ShellY !== e.y ||
          bus.ShellActive !== e.act || bus.Fired !== e.fired) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t: got x=%0d y=%0d act=%0b fired=%0b, expected x=%0d y=%0d act=%0b fired=%0b",
                 $time, bus.ShellX, bus.ShellY, bus.ShellActive, bus.Fired,
                 e.x, e.y, e.act, e.fired);
      end
      if (bus.Fired === 1'b1) dut_fired_cnt++;
    end
  end

  task automatic step(input bit rst_n, input int key, input int tx, input int ty, input bit h);
    exp_t e;
    bit press;
    @(negedge frame_clk);
    Reset_n     = rst_n;
    bus.keycode = key[7:0];
    bus.TankX   = tx[9:0];
    bus.TankY   = ty[9:0];
    bus.hit     = h;
    if (!rst_n) begin
      m_x = 0; m_y = 0; m_cd = 0; m_active = 0; m_prev = 0; m_fired = 0;
    end else begin
      press   = (key == KEY_FIRE) && !m_prev;
      m_fired = 0;
      if (m_active) begin
        if (h || m_y < Y_MIN + STEP) begin
          m_active = 0;
          m_cd     = COOL;
        end else begin
          m_y = m_y - STEP;
        end
      end else if (m_cd > 0) begin
        m_cd = m_cd - 1;
      end else if (press && ty >= OFFSET) begin
        m_x = tx; m_y = ty - OFFSET; m_active = 1; m_fired = 1;
      end
      m_prev = (key == KEY_FIRE);
    end
    e.x = m_x[9:0];
    e.y = m_y[9:0];
    e.act = m_active;
    e.fired = m_fired;
    sb_q.push_back(e);
  endtask

  task automatic settle();
    @(posedge frame_clk);
    #2;
  endtask

  task automatic expect_now(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int fc0;
    int key;
    int ty;
    bus.keycode = 8'h00;
    bus.TankX   = 10'd0;
    bus.TankY   = 10'd0;
    bus.hit     = 1'b0;

    // Reset
    step(0, 0, 0, 0, 0);
    step(0, KEY_FIRE, 350, 500, 0);
    settle();
    expect_now("reset_active", bus.ShellActive, 0);
    expect_now("reset_y", bus.ShellY, 0);

    // Launch and first step
    step(1, KEY_FIRE, 350, 500, 0);
    settle();
    expect_now("launch_x", bus.ShellX, 350);
    expect_now("launch_y", bus.ShellY, 492);
    expect_now("launch_fired", bus.Fired, 1);
    step(1, 0, 350, 500, 0);
    settle();
    expect_now("step1_y", bus.ShellY, 488);
    expect_now("step1_fired", bus.Fired, 0);

    // Fly to the top: 123 steps total reach 0, then exit
    for (int i = 0; i < 122; i++) step(1, 0, 350, 500, 0);
    settle();
    expect_now("top_y", bus.ShellY, 0);
    expect_now("top_active", bus.ShellActive, 1);
    step(1, 0, 350, 500, 0);
    settle();
    expect_now("exit_active", bus.ShellActive, 0);
    expect_now("exit_y_hold", bus.ShellY, 0);

    // Press on the 15th cooldown frame is lost
    for (int i = 0; i < 14; i++) step(1, 0, 350, 500, 0);
    step(1, KEY_FIRE, 350, 500, 0);
    step(1, KEY_FIRE, 350, 500, 0);
    settle();
    expect_now("cool_press_lost", bus.ShellActive, 0);
    step(1, 0, 350, 500, 0);
    step(1, KEY_FIRE, 350, 500, 0);
    settle();
    expect_now("relaunch_fired", bus.Fired, 1);

    // Hit at y=452 with TankX moved mid-flight
    for (int i = 0; i < 10; i++) step(1, 0, 200, 500, 0);
    settle();
    expect_now("pre_hit_y", bus.ShellY, 452);
    step(1, 0, 200, 500, 1);
    settle();
    expect_now("hit_active", bus.ShellActive, 0);
    expect_now("hit_y_hold", bus.ShellY, 452);
    expect_now("hit_x_fixed", bus.ShellX, 350);
    for (int i = 0; i < COOL; i++) step(1, 0, 200, 500, 0);

    // Hold fire key for 200 frames -> exactly one pulse
    settle();
    fc0 = dut_fired_cnt;
    for (int i = 0; i < 200; i++) step(1, KEY_FIRE, 300, 400, 0);
    settle();
    expect_now("hold_one_pulse", dut_fired_cnt - fc0, 1);
    step(1, 0, 300, 400, 0);

    // Spawn would underflow -> dropped
    step(1, KEY_FIRE, 100, 5, 0);
    settle();
    expect_now("low_tank_no_launch", bus.ShellActive, 0);
    step(1, 0, 100, 5, 0);

    // Reset mid-flight, then fresh launch
    step(1, KEY_FIRE, 600, 300, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 600, 300, 0);
    step(0, 0, 600, 300, 0);
    settle();
    expect_now("midreset_active", bus.ShellActive, 0);
    expect_now("midreset_x", bus.ShellX, 0);
    step(1, 0, 600, 300, 0);
    step(1, KEY_FIRE, 600, 300, 0);
    settle();
    expect_now("post_reset_launch_y", bus.ShellY, 292);

    // Random frames against the model
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: key = KEY_FIRE;
        4:          key = $urandom_range(0, 255);
        default:    key = 0;
      endcase
      ty = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 12) : $urandom_range(0, 1023);
      step(($urandom_range(0, 199) != 0), key, $urandom_range(0, 1023), ty,
           ($urandom_range(0, 29) == 0));
    end

    settle();
    expect_now("scoreboard_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
